izhikevich_array: RTL

Time-multiplexed, clocked array of NUM_NEURONS Izhikevich neurons in signed fixed point (N bits, Q fractional).
- Per-neuron membrane voltage v and recovery w are held in internal register arrays.
- One shared datapath advances every neuron by one Euler step per `step` request.
- Per-neuron spike flags are produced for the downstream synapse/routing logic.
- Replaces the single-neuron combinational core as the network-level building block.

---
 rtl/izhikevich_array.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/izhikevich_array.sv
// izhikevich_array: time-multiplexed array of Izhikevich neurons in signed
// fixed point. The membrane voltage v and recovery w of every neuron live in
// register arrays. One shared saturating datapath walks the neurons in index
// order, taking FETCH -> CALC -> WRITE for each, and then signals done.
//
// Optional build macro: IZH_REFRACTORY_EN adds a per-neuron refractory
// counter. While a neuron's counter is nonzero its voltage is held and it
// cannot spike.
//
// state  | meaning
// IDLE   | waiting for init (reload all neurons) or step (start a sweep)
// FETCH  | latch v/w/i of neuron idx into operand registers
// CALC   | register dv and dw from the operands
// WRITE  | commit the new v/w/spike for neuron idx, advance idx
// FINISH | sweep complete, raise done for one cycle
module izhikevich_array #(
  parameter int N              = 32,
  parameter int Q              = 16,
  parameter int NUM_NEURONS    = 8,
  parameter int ADDR_W         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_NEURONS*N-1:0] i_flat,
  input  logic [N-1:0]             v_init,
  input  logic [N-1:0]             w_init,
  input  logic [N-1:0]             v_th,
  input  logic [N-1:0]             dt,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic [N-1:0]             c,
  input  logic [N-1:0]             d,
  input  logic                     init,
  input  logic                     step,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_NEURONS-1:0]   spikes,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [N-1:0]             rd_voltage,
  output logic [N-1:0]             rd_w
);

  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
  // 0.04, 5 and 140 in Q format; 0.04 is rounded to the nearest LSB.
  localparam longint K_004_L = ((longint'(1) << Q) * 4 + 50) / 100;
  localparam logic [N-1:0] K_004 = N'(K_004_L);
  localparam logic [N-1:0] K_5   = N'(longint'(5) << Q);
  localparam logic [N-1:0] K_140 = N'(longint'(140) << Q);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CALC, WRITE, FINISH} state_t;

  state_t state, state_nxt;

  logic [N-1:0]      v_mem [NUM_NEURONS];
  logic [N-1:0]      w_mem [NUM_NEURONS];
  logic [ADDR_W-1:0] idx;
  logic              done_q;
  logic [N-1:0]      op_v, op_w, op_i;
  logic [N-1:0]      dv_q, dw_q;
  logic [N-1:0]      vv, quad, lin, s1, s2, s3, s4, dv_c;
  logic [N-1:0]      bv, rec, arec, dw_c;
  logic              fire;

`ifdef IZH_REFRACTORY_EN
  localparam int RC_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  logic [RC_W-1:0] ref_cnt [NUM_NEURONS];
`endif

  // Full-width signed product, floor shift by Q, clamp to the N-bit range.
  function automatic logic [N-1:0] sat_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] shr;
    prod = $signed({{N{x[N-1]}}, x}) * $signed({{N{y[N-1]}}, y});
    shr  = prod >>> Q;
    if (shr[2*N-1:N-1] == {(N+1){shr[2*N-1]}}) sat_mul = shr[N-1:0];
    else if (shr[2*N-1])                        sat_mul = SAT_MIN;
    else                                        sat_mul = SAT_MAX;
  endfunction

  function automatic logic [N-1:0] sat_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    s = {x[N-1], x} + {y[N-1], y};
    if (s[N] == s[N-1]) sat_add = s[N-1:0];
    else if (s[N])      sat_add = SAT_MIN;
    else                sat_add = SAT_MAX;
  endfunction

  function automatic logic [N-1:0] sat_sub(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    s = {x[N-1], x} - {y[N-1], y};
    if (s[N] == s[N-1]) sat_sub = s[N-1:0];
    else if (s[N])      sat_sub = SAT_MIN;
    else                sat_sub = SAT_MAX;
  endfunction

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; init outranks step, both ignored outside IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!init && step) state_nxt = FETCH;
      FETCH:   state_nxt = CALC;
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = (idx == LAST_IDX) ? FINISH : FETCH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs; done is the registered FINISH flag so it lands in IDLE.
  always_comb begin
    busy = (state != IDLE);
    done = done_q;
  end

  // Euler increments of the latched neuron, every operation saturating.
  always_comb begin
    vv   = sat_mul(op_v, op_v);
    quad = sat_mul(K_004, vv);
    lin  = sat_mul(K_5, op_v);
    s1   = sat_add(quad, lin);
    s2   = sat_add(s1, K_140);
    s3   = sat_sub(s2, op_w);
    s4   = sat_add(s3, op_i);
    dv_c = sat_mul(dt, s4);
    bv   = sat_mul(b, op_v);
    rec  = sat_sub(bv, op_w);
    arec = sat_mul(a, rec);
    dw_c = sat_mul(dt, arec);
    fire = ($signed(op_v) >= $signed(v_th));
  end

  // Neuron state arrays, operand/increment registers and sweep index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_mem[k] <= v_init;
        w_mem[k] <= w_init;
`ifdef IZH_REFRACTORY_EN
        ref_cnt[k] <= '0;
`endif
      end
      spikes <= '0;
      idx    <= '0;
      done_q <= 1'b0;
      op_v   <= '0;
      op_w   <= '0;
      op_i   <= '0;
      dv_q   <= '0;
      dw_q   <= '0;
    end else begin
      done_q <= (state == FINISH);
      case (state)
        IDLE: begin
          if (init) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
              v_mem[k] <= v_init;
              w_mem[k] <= w_init;
`ifdef IZH_REFRACTORY_EN
              ref_cnt[k] <= '0;
`endif
            end
            spikes <= '0;
          end else if (step) begin
            idx <= '0;
          end
        end
        FETCH: begin
          op_v <= v_mem[idx];
          op_w <= w_mem[idx];
          op_i <= i_flat[int'(idx)*N +: N];
        end
        CALC: begin
          dv_q <= dv_c;
          dw_q <= dw_c;
        end
        WRITE: begin
`ifdef IZH_REFRACTORY_EN
          if (ref_cnt[idx] != '0) begin
            v_mem[idx]   <= op_v;
            w_mem[idx]   <= sat_add(op_w, dw_q);
            spikes[idx]  <= 1'b0;
            ref_cnt[idx] <= ref_cnt[idx] - 1'b1;
          end else if (fire) begin
            v_mem[idx]   <= c;
            w_mem[idx]   <= sat_add(op_w, d);
            spikes[idx]  <= 1'b1;
            ref_cnt[idx] <= RC_W'(REFRACT_CYCLES);
          end else begin
            v_mem[idx]  <= sat_add(op_v, dv_q);
            w_mem[idx]  <= sat_add(op_w, dw_q);
            spikes[idx] <= 1'b0;
          end
`else
          if (fire) begin
            v_mem[idx]  <= c;
            w_mem[idx]  <= sat_add(op_w, d);
            spikes[idx] <= 1'b1;
          end else begin
            v_mem[idx]  <= sat_add(op_v, dv_q);
            w_mem[idx]  <= sat_add(op_w, dw_q);
            spikes[idx] <= 1'b0;
          end
`endif
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Combinational readback of the selected neuron.
  always_comb begin
    rd_voltage = v_mem[rd_addr];
    rd_w       = w_mem[rd_addr];
  end

endmodule
